// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the fetch FSM state encoding and the FIFO entry layout.
package riscv_fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      STALL   = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Instruction addresses are word aligned; the low two bits are dropped.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries.
// A pop frees space before a same-cycle push, so push+pop works when full.
module fetch_fifo
   import riscv_fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [CW-1:0] count,
   output logic         full,
   output logic         empty
);

   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   fetch_entry_t  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_next_s;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full  = (count_r == CNT_FULL);
   assign empty = (count_r == {CW{1'b0}});
   assign count = count_r;

   // Accept handshakes and compute the occupancy after this cycle.
   always_comb begin
      pop_ok_s     = pop && !empty;
      push_ok_s    = push && (!full || pop_ok_s);
      count_next_s = count_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_next_s = count_r + CNT_ONE;
         2'b01:   count_next_s = count_r - CNT_ONE;
         default: count_next_s = count_r;
      endcase
   end

   // Head entry reads as zero while the FIFO is empty.
   always_comb begin
      head = '0;
      if (!empty) begin
         head = mem_r[rd_ptr_r];
      end else begin
         head = '0;
      end
   end

   // Storage, pointers and occupancy; clear drops everything in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_next_s;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one word request at a time to instruction
// memory, buffers returned words and handles branch/jump redirects.
module instr_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   fetch_state_t  state_r;
   fetch_state_t  state_next_s;
   logic [31:0]   pc_r;
   logic [31:0]   pc_next_s;
   logic [31:0]   addr_r;
   logic [31:0]   addr_next_s;
   logic [31:0]   target_s;
   logic          req_s;
   logic          ack_s;
   logic          push_s;
   logic          pop_s;
   logic          clear_s;
   logic [CW-1:0] count_s;
   logic [CW-1:0] count_after_s;
   logic          full_s;
   logic          empty_s;
   fetch_entry_t  push_entry_s;
   fetch_entry_t  head_s;

   // pc_r is the next fetch target; addr_r is what is on the bus, and the two
   // differ only in DISCARD while the stale request is still outstanding.
   assign imem_req    = req_s && !reset;
   assign imem_addr   = addr_r;
   assign instr_valid = !empty_s;
   assign instr_out   = head_s.instr;
   assign instr_pc    = head_s.pc;

   assign push_entry_s.pc    = addr_r;
   assign push_entry_s.instr = imem_rdata;

   // Next-state, PC and FIFO control; redirect outranks push and pop.
   always_comb begin
      state_next_s  = state_r;
      pc_next_s     = pc_r;
      addr_next_s   = addr_r;
      clear_s       = 1'b0;
      target_s      = align_word(redirect_pc);
      req_s         = (state_r != STALL);
      ack_s         = imem_ack && req_s;
      pop_s         = !empty_s && instr_ready && !redirect;
      push_s        = (state_r == FETCH) && ack_s && !redirect && (!full_s || pop_s);
      count_after_s = count_s + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};

      case (state_r)
         FETCH: begin
            if (redirect) begin
               clear_s   = 1'b1;
               pc_next_s = target_s;
               if (ack_s) begin
                  addr_next_s  = target_s;
                  state_next_s = FETCH;
               end else begin
                  addr_next_s  = addr_r;
                  state_next_s = DISCARD;
               end
            end else if (push_s) begin
               pc_next_s   = pc_r + PC_STEP;
               addr_next_s = pc_r + PC_STEP;
               if (count_after_s == CNT_FULL) begin
                  state_next_s = STALL;
               end else begin
                  state_next_s = FETCH;
               end
            end else begin
               state_next_s = FETCH;
            end
         end
         STALL: begin
            if (redirect) begin
               clear_s      = 1'b1;
               pc_next_s    = target_s;
               addr_next_s  = target_s;
               state_next_s = FETCH;
            end else if (count_after_s != CNT_FULL) begin
               state_next_s = FETCH;
            end else begin
               state_next_s = STALL;
            end
         end
         DISCARD: begin
            if (redirect) begin
               clear_s   = 1'b1;
               pc_next_s = target_s;
               if (ack_s) begin
                  addr_next_s  = target_s;
                  state_next_s = FETCH;
               end else begin
                  state_next_s = DISCARD;
               end
            end else if (ack_s) begin
               addr_next_s  = pc_r;
               state_next_s = FETCH;
            end else begin
               state_next_s = DISCARD;
            end
         end
         default: begin
            clear_s      = 1'b1;
            pc_next_s    = RESET_PC;
            addr_next_s  = RESET_PC;
            state_next_s = FETCH;
         end
      endcase
   end

   // FSM state, fetch PC and bus address registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= FETCH;
         pc_r    <= RESET_PC;
         addr_r  <= RESET_PC;
      end else begin
         state_r <= state_next_s;
         pc_r    <= pc_next_s;
         addr_r  <= addr_next_s;
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear_s),
      .push     (push_s),
      .push_data(push_entry_s),
      .pop      (pop_s),
      .head     (head_s),
      .count    (count_s),
      .full     (full_s),
      .empty    (empty_s)
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a simple
// programmable-latency instruction memory responder.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;

   logic mem_en = 1'b0;
   logic force_ack = 1'b0;
   int   lat = 0;
   int   wait_cnt = 0;
   int   total = 0;
   int   bad = 0;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .instr_out  (instr_out),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .redirect   (redirect),
      .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a ^ 32'hA5A5_0000) + 32'h0000_0013;
   endfunction

   assign imem_ack   = force_ack | (mem_en && imem_req && (wait_cnt >= lat));
   assign imem_rdata = word_of(imem_addr);

   always @(posedge clk) begin
      if (imem_ack) wait_cnt <= 0;
      else if (imem_req) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic en, input int l, input logic rdy);
      reset = 1'b1; redirect = 1'b0; force_ack = 1'b0;
      mem_en = en; lat = l; instr_ready = rdy;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; mem_en = 1'b1; lat = 0;
      step();
      step();
      #1;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
      total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=00000000", instr_out); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=00000000", instr_pc); end
   endtask

   task automatic test_stream();
      do_reset(1'b1, 0, 1'b1);
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL stream_c0 req=%b addr=%h valid=%b exp 1/00000000/0", imem_req, imem_addr, instr_valid);
      end
      for (int k = 1; k <= 5; k++) begin
         step();
         total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
            bad++; $display("FAIL stream_addr k=%0d req=%b addr=%h exp=%h", k, imem_req, imem_addr, 32'(4 * k));
         end
         total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (k - 1)) || instr_out !== word_of(32'(4 * (k - 1)))) begin
            bad++; $display("FAIL stream_out k=%0d valid=%b pc=%h instr=%h exp pc=%h", k, instr_valid, instr_pc, instr_out, 32'(4 * (k - 1)));
         end
      end
   endtask

   task automatic test_full();
      int acks;
      acks = 0;
      do_reset(1'b1, 0, 1'b0);
      for (int c = 0; c < 6; c++) begin
         if (imem_ack) acks++;
         step();
      end
      total++; if (acks !== 2) begin bad++; $display("FAIL full_acks got=%0d exp=2", acks); end
      total++; if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
         bad++; $display("FAIL full_stall req=%b valid=%b pc=%h exp 0/1/00000000", imem_req, instr_valid, instr_pc);
      end
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_pc !== 32'h4) begin
         bad++; $display("FAIL full_reissue req=%b addr=%h pc=%h exp 1/00000008/00000004", imem_req, imem_addr, instr_pc);
      end
   endtask

   task automatic test_redirect_wait();
      int n;
      do_reset(1'b1, 3, 1'b1);
      step();
      redirect = 1'b1; redirect_pc = 32'h0000_0100;
      #1;
      step();
      redirect = 1'b0;
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL rdw_hold req=%b addr=%h valid=%b exp 1/00000000/0", imem_req, imem_addr, instr_valid);
      end
      n = 0;
      while (!imem_ack && n < 10) begin step(); n++; end
      total++; if (n >= 10 || imem_addr !== 32'h0) begin
         bad++; $display("FAIL rdw_ack waited=%0d addr=%h exp ack at addr 00000000", n, imem_addr);
      end
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL rdw_target req=%b addr=%h valid=%b exp 1/00000100/0", imem_req, imem_addr, instr_valid);
      end
      n = 0;
      while (!instr_valid && n < 10) begin step(); n++; end
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_out !== word_of(32'h100)) begin
         bad++; $display("FAIL rdw_first valid=%b pc=%h instr=%h exp pc=00000100", instr_valid, instr_pc, instr_out);
      end
   endtask

   task automatic test_redirect_ack();
      do_reset(1'b1, 0, 1'b0);
      step();
      redirect = 1'b1; redirect_pc = 32'h0000_0200; instr_ready = 1'b1;
      #1;
      total++; if (imem_ack !== 1'b1 || instr_valid !== 1'b1) begin
         bad++; $display("FAIL rda_pre ack=%b valid=%b exp 1/1", imem_ack, instr_valid);
      end
      step();
      redirect = 1'b0;
      #1;
      total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         bad++; $display("FAIL rda_flush valid=%b req=%b addr=%h exp 0/1/00000200", instr_valid, imem_req, imem_addr);
      end
      step();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
         bad++; $display("FAIL rda_first valid=%b pc=%h exp 1/00000200", instr_valid, instr_pc);
      end
      step();
      total++; if (instr_pc !== 32'h204) begin bad++; $display("FAIL rda_second pc=%h exp=00000204", instr_pc); end
      // redirect while stalled on a full FIFO, coincident with a pop
      do_reset(1'b1, 0, 1'b0);
      step();
      step();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rds_stall req=%b exp=0", imem_req); end
      instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0303;
      #1;
      step();
      redirect = 1'b0;
      #1;
      total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
         bad++; $display("FAIL rds_flush valid=%b req=%b addr=%h exp 0/1/00000300", instr_valid, imem_req, imem_addr);
      end
      step();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin
         bad++; $display("FAIL rds_first valid=%b pc=%h exp 1/00000300", instr_valid, instr_pc);
      end
   endtask

   task automatic test_wrap();
      do_reset(1'b1, 0, 1'b1);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      #1;
      step();
      redirect = 1'b0;
      #1;
      total++; if (imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
         bad++; $display("FAIL wrap_first addr=%h valid=%b exp FFFFFFFC/0", imem_addr, instr_valid);
      end
      step();
      total++; if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC) begin
         bad++; $display("FAIL wrap_next addr=%h pc=%h exp 00000000/FFFFFFFC", imem_addr, instr_pc);
      end
      step();
      total++; if (instr_pc !== 32'h0 || imem_addr !== 32'h4) begin
         bad++; $display("FAIL wrap_after pc=%h addr=%h exp 00000000/00000004", instr_pc, imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b1, 0, 1'b0);
      step();
      lat = 5;
      #1;
      total++; if (imem_req !== 1'b1 || instr_valid !== 1'b1) begin
         bad++; $display("FAIL rmid_pre req=%b valid=%b exp 1/1", imem_req, instr_valid);
      end
      reset = 1'b1;
      step();
      force_ack = 1'b1;
      #1;
      total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_pc !== 32'h0) begin
         bad++; $display("FAIL rmid_reset valid=%b req=%b addr=%h pc=%h exp 0/0/00000000/00000000", instr_valid, imem_req, imem_addr, instr_pc);
      end
      step();
      force_ack = 1'b0; reset = 1'b0; lat = 0;
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
         bad++; $display("FAIL rmid_restart req=%b addr=%h valid=%b exp 1/00000000/0", imem_req, imem_addr, instr_valid);
      end
      step();
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_out !== word_of(32'h0)) begin
         bad++; $display("FAIL rmid_first valid=%b pc=%h instr=%h exp pc=00000000", instr_valid, instr_pc, instr_out);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_ack();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
